// File: rtl/biriscv_csr_pipe_pkg.sv
// Shared defines for the CSR E2/WB pipe: exception codes, CSR address field and stage record.
// BIRISCV_CSR_PIPE_TVAL_EN adds a tval field to the stage record.
package biriscv_csr_pipe_pkg;

  localparam int EXCEPTION_W = 6;

  localparam logic [EXCEPTION_W-1:0] EXCEPTION_NONE                = 6'h00;
  localparam logic [EXCEPTION_W-1:0] EXCEPTION_MISALIGNED_FETCH    = 6'h10;
  localparam logic [EXCEPTION_W-1:0] EXCEPTION_FAULT_FETCH         = 6'h11;
  localparam logic [EXCEPTION_W-1:0] EXCEPTION_ILLEGAL_INSTRUCTION = 6'h12;
  localparam logic [EXCEPTION_W-1:0] EXCEPTION_BREAKPOINT          = 6'h13;
  localparam logic [EXCEPTION_W-1:0] EXCEPTION_MISALIGNED_LOAD     = 6'h14;
  localparam logic [EXCEPTION_W-1:0] EXCEPTION_FAULT_LOAD          = 6'h15;
  localparam logic [EXCEPTION_W-1:0] EXCEPTION_MISALIGNED_STORE    = 6'h16;
  localparam logic [EXCEPTION_W-1:0] EXCEPTION_FAULT_STORE         = 6'h17;
  localparam logic [EXCEPTION_W-1:0] EXCEPTION_ECALL               = 6'h18;
  localparam logic [EXCEPTION_W-1:0] EXCEPTION_INTERRUPT           = 6'h20;
  localparam logic [EXCEPTION_W-1:0] EXCEPTION_ERET_M              = 6'h33;
  localparam logic [EXCEPTION_W-1:0] EXCEPTION_FENCE               = 6'h34;

  localparam int CSR_ADDR_HI = 31;
  localparam int CSR_ADDR_LO = 20;
  localparam int CSR_ADDR_W  = CSR_ADDR_HI - CSR_ADDR_LO + 1;

  typedef struct packed {
    logic                   valid;
    logic [31:0]            pc;
    logic [CSR_ADDR_W-1:0]  opcode;
    logic                   csr_write;
    logic [31:0]            wdata;
    logic [EXCEPTION_W-1:0] exception;
`ifdef BIRISCV_CSR_PIPE_TVAL_EN
    logic [31:0]            tval;
`endif
  } csr_stage_t;

  // A FENCE flush still lets the CSR write land (satp update followed by refetch).
  function automatic logic write_allowed(input logic [EXCEPTION_W-1:0] exc);
    return (exc == EXCEPTION_NONE) || (exc == EXCEPTION_FENCE);
  endfunction

endpackage

// File: rtl/biriscv_csr_pipe_stage.sv
// Valid-qualified CSR pipe stage register; kill beats hold, hold beats load.
module biriscv_csr_pipe_stage
  import biriscv_csr_pipe_pkg::*;
(
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       hold_i,
  input  logic       kill_i,
  input  csr_stage_t d_i,
  output csr_stage_t q_o
);

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i)
      q_o <= '0;
    else if (kill_i)
      q_o <= '0;
    else if (!hold_i)
      q_o <= d_i;
  end

endmodule

// File: rtl/biriscv_csr_pipe.sv
// CSR result pipe from E1 through E2 and WB into the CSR unit's write-back/exception inputs.
// Define BIRISCV_CSR_PIPE_TVAL_EN to track tval per stage; otherwise the exception address is 0.
module biriscv_csr_pipe
  import biriscv_csr_pipe_pkg::*;
(
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic                   e1_valid_i,
  input  logic [31:0]            e1_pc_i,
  input  logic [31:0]            e1_opcode_i,
  input  logic                   e1_csr_write_i,
  input  logic [31:0]            e1_csr_wdata_i,
  input  logic [31:0]            e1_csr_value_i,
  input  logic [EXCEPTION_W-1:0] e1_exception_i,
  input  logic                   squash_e1_i,
  input  logic                   stall_i,
  input  logic [EXCEPTION_W-1:0] e2_mem_exception_i,
  input  logic [31:0]            e2_mem_addr_i,
  output logic                   csr_writeback_write_o,
  output logic [CSR_ADDR_W-1:0]  csr_writeback_waddr_o,
  output logic [31:0]            csr_writeback_wdata_o,
  output logic [EXCEPTION_W-1:0] csr_writeback_exception_o,
  output logic [31:0]            csr_writeback_exception_pc_o,
  output logic [31:0]            csr_writeback_exception_addr_o,
  output logic                   flush_o
);

  csr_stage_t e2_d, e2_q;
  csr_stage_t wb_d, wb_q;

  always_comb begin
    e2_d           = '0;
    e2_d.valid     = e1_valid_i & ~squash_e1_i;
    e2_d.pc        = e1_pc_i;
    e2_d.opcode    = e1_opcode_i[CSR_ADDR_HI:CSR_ADDR_LO];
    e2_d.csr_write = e1_csr_write_i;
    e2_d.wdata     = e1_csr_wdata_i;
    e2_d.exception = e1_exception_i;
`ifdef BIRISCV_CSR_PIPE_TVAL_EN
    e2_d.tval      = e1_csr_value_i;
`endif
  end

  // A flush in WB kills E2 and drops the incoming E1 instruction in the same edge.
  biriscv_csr_pipe_stage u_e2 (
    .clk_i  (clk_i),
    .rst_i  (rst_i),
    .hold_i (stall_i),
    .kill_i (flush_o),
    .d_i    (e2_d),
    .q_o    (e2_q)
  );

  // Early exceptions take precedence over the LSU fault for the same instruction.
  always_comb begin
    wb_d = e2_q;
    if ((e2_q.exception == EXCEPTION_NONE) && (e2_mem_exception_i != EXCEPTION_NONE)) begin
      wb_d.exception = e2_mem_exception_i;
`ifdef BIRISCV_CSR_PIPE_TVAL_EN
      wb_d.tval      = e2_mem_addr_i;
`endif
    end
    wb_d.csr_write = e2_q.csr_write & write_allowed(wb_d.exception);
  end

  // WB takes a bubble on stall so a held E2 write can never strobe twice.
  biriscv_csr_pipe_stage u_wb (
    .clk_i  (clk_i),
    .rst_i  (rst_i),
    .hold_i (1'b0),
    .kill_i (flush_o | stall_i),
    .d_i    (wb_d),
    .q_o    (wb_q)
  );

  assign flush_o                      = wb_q.valid & (wb_q.exception != EXCEPTION_NONE);
  assign csr_writeback_write_o        = wb_q.valid & wb_q.csr_write;
  assign csr_writeback_waddr_o        = wb_q.valid ? wb_q.opcode    : '0;
  assign csr_writeback_wdata_o        = wb_q.valid ? wb_q.wdata     : '0;
  assign csr_writeback_exception_o    = wb_q.valid ? wb_q.exception : '0;
  assign csr_writeback_exception_pc_o = wb_q.valid ? wb_q.pc        : '0;

`ifdef BIRISCV_CSR_PIPE_TVAL_EN
  assign csr_writeback_exception_addr_o = wb_q.valid ? wb_q.tval : '0;
  logic unused_opcode;
  assign unused_opcode = ^e1_opcode_i[CSR_ADDR_LO-1:0];
`else
  assign csr_writeback_exception_addr_o = '0;
  logic unused_inputs;
  assign unused_inputs = ^{e1_csr_value_i, e2_mem_addr_i, e1_opcode_i[CSR_ADDR_LO-1:0]};
`endif

endmodule

// File: tb/tb_biriscv_csr_pipe.sv
// Directed bench for biriscv_csr_pipe: hand-computed vectors checked with immediate assertions.
module tb_biriscv_csr_pipe;
  import biriscv_csr_pipe_pkg::*;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic        e1_valid_i;
  logic [31:0] e1_pc_i;
  logic [31:0] e1_opcode_i;
  logic        e1_csr_write_i;
  logic [31:0] e1_csr_wdata_i;
  logic [31:0] e1_csr_value_i;
  logic [5:0]  e1_exception_i;
  logic        squash_e1_i;
  logic        stall_i;
  logic [5:0]  e2_mem_exception_i;
  logic [31:0] e2_mem_addr_i;
  logic        csr_writeback_write_o;
  logic [11:0] csr_writeback_waddr_o;
  logic [31:0] csr_writeback_wdata_o;
  logic [5:0]  csr_writeback_exception_o;
  logic [31:0] csr_writeback_exception_pc_o;
  logic [31:0] csr_writeback_exception_addr_o;
  logic        flush_o;

  int vectors = 0;
  int miscompares = 0;

  biriscv_csr_pipe dut (
    .clk_i                          (clk_i),
    .rst_i                          (rst_i),
    .e1_valid_i                     (e1_valid_i),
    .e1_pc_i                        (e1_pc_i),
    .e1_opcode_i                    (e1_opcode_i),
    .e1_csr_write_i                 (e1_csr_write_i),
    .e1_csr_wdata_i                 (e1_csr_wdata_i),
    .e1_csr_value_i                 (e1_csr_value_i),
    .e1_exception_i                 (e1_exception_i),
    .squash_e1_i                    (squash_e1_i),
    .stall_i                        (stall_i),
    .e2_mem_exception_i             (e2_mem_exception_i),
    .e2_mem_addr_i                  (e2_mem_addr_i),
    .csr_writeback_write_o          (csr_writeback_write_o),
    .csr_writeback_waddr_o          (csr_writeback_waddr_o),
    .csr_writeback_wdata_o          (csr_writeback_wdata_o),
    .csr_writeback_exception_o      (csr_writeback_exception_o),
    .csr_writeback_exception_pc_o   (csr_writeback_exception_pc_o),
    .csr_writeback_exception_addr_o (csr_writeback_exception_addr_o),
    .flush_o                        (flush_o)
  );

  always #5 clk_i = ~clk_i;

  // Expected exception address: the tval when tracked, otherwise always 0.
  function automatic logic [31:0] tv(input logic [31:0] v);
`ifdef BIRISCV_CSR_PIPE_TVAL_EN
    return v;
`else
    return 32'h0;
`endif
  endfunction

  task automatic tick;
    @(posedge clk_i);
    #1;
  endtask

  task automatic applyStimulus(input logic v, input logic [31:0] pc, input logic [31:0] op,
                               input logic wr, input logic [31:0] wdata,
                               input logic [31:0] value, input logic [5:0] exc);
    e1_valid_i     = v;
    e1_pc_i        = pc;
    e1_opcode_i    = op;
    e1_csr_write_i = wr;
    e1_csr_wdata_i = wdata;
    e1_csr_value_i = value;
    e1_exception_i = exc;
  endtask

  task automatic applyBubble;
    applyStimulus(1'b0, 32'h0, 32'h0, 1'b0, 32'h0, 32'h0, 6'h0);
  endtask

  task automatic cmp(input string tag, input string field, input logic [31:0] got,
                     input logic [31:0] exp);
    vectors++;
    assert (got === exp)
    else begin
      miscompares++;
      $error("[TB] FAIL %s.%s observed %08h expected %08h", tag, field, got, exp);
    end
  endtask

  task automatic checkOutput(input string tag, input logic wr, input logic [11:0] waddr,
                             input logic [31:0] wdata, input logic [5:0] exc,
                             input logic [31:0] pc, input logic [31:0] addr,
                             input logic flush);
    cmp(tag, "write", {31'h0, csr_writeback_write_o},           {31'h0, wr});
    cmp(tag, "waddr", {20'h0, csr_writeback_waddr_o},           {20'h0, waddr});
    cmp(tag, "wdata", csr_writeback_wdata_o,                    wdata);
    cmp(tag, "exc",   {26'h0, csr_writeback_exception_o},       {26'h0, exc});
    cmp(tag, "pc",    csr_writeback_exception_pc_o,             pc);
    cmp(tag, "addr",  csr_writeback_exception_addr_o,           addr);
    cmp(tag, "flush", {31'h0, flush_o},                         {31'h0, flush});
  endtask

  task automatic checkIdle(input string tag);
    checkOutput(tag, 1'b0, 12'h0, 32'h0, 6'h0, 32'h0, 32'h0, 1'b0);
  endtask

  initial begin
    rst_i = 1'b1;
    squash_e1_i = 1'b0;
    stall_i = 1'b0;
    e2_mem_exception_i = 6'h0;
    e2_mem_addr_i = 32'h0;
    applyBubble();
    repeat (2) tick();
    checkIdle("reset");
    rst_i = 1'b0;
    tick();
    checkIdle("post_reset");

    // csrrw x0, 0x340, x5
    applyStimulus(1'b1, 32'h80000010, 32'h34029073, 1'b1, 32'hDEADBEEF, 32'h11111111, 6'h0);
    tick();
    applyBubble();
    tick();
    checkOutput("csrrw", 1'b1, 12'h340, 32'hDEADBEEF, 6'h0, 32'h80000010, tv(32'h11111111), 1'b0);
    tick();
    checkIdle("csrrw_after");

    // Illegal mret; the next two instructions must be killed by the flush
    applyStimulus(1'b1, 32'h80000020, 32'h30200073, 1'b0, 32'h0, 32'h30200073,
                  EXCEPTION_ILLEGAL_INSTRUCTION);
    tick();
    applyStimulus(1'b1, 32'h80000024, 32'h34029073, 1'b1, 32'h12345678, 32'h0, 6'h0);
    tick();
    applyStimulus(1'b1, 32'h80000028, 32'h34029073, 1'b1, 32'hAAAA5555, 32'h0, 6'h0);
    checkOutput("illegal", 1'b0, 12'h302, 32'h0, EXCEPTION_ILLEGAL_INSTRUCTION,
                32'h80000020, tv(32'h30200073), 1'b1);
    tick();
    applyBubble();
    checkIdle("illegal_kill1");
    tick();
    checkIdle("illegal_kill2");

    // Faulting CSR write is suppressed
    applyStimulus(1'b1, 32'h8000002C, 32'h34029073, 1'b1, 32'hCAFEF00D, 32'h34029073,
                  EXCEPTION_ILLEGAL_INSTRUCTION);
    tick();
    applyBubble();
    tick();
    checkOutput("suppress", 1'b0, 12'h340, 32'hCAFEF00D, EXCEPTION_ILLEGAL_INSTRUCTION,
                32'h8000002C, tv(32'h34029073), 1'b1);
    tick();
    checkIdle("suppress_after");

    // Clean load faulting in the LSU at E2
    applyStimulus(1'b1, 32'h80000030, 32'h0000A083, 1'b0, 32'h0, 32'h0, 6'h0);
    tick();
    applyBubble();
    e2_mem_exception_i = EXCEPTION_FAULT_LOAD;
    e2_mem_addr_i = 32'h00001003;
    tick();
    e2_mem_exception_i = 6'h0;
    e2_mem_addr_i = 32'h0;
    checkOutput("fault_load", 1'b0, 12'h000, 32'h0, EXCEPTION_FAULT_LOAD, 32'h80000030,
                tv(32'h00001003), 1'b1);
    tick();
    checkIdle("fault_load_after");

    // satp write with FENCE still commits
    applyStimulus(1'b1, 32'h80000040, 32'h18029073, 1'b1, 32'h80012345, 32'h18029073,
                  EXCEPTION_FENCE);
    tick();
    applyBubble();
    tick();
    checkOutput("satp_fence", 1'b1, 12'h180, 32'h80012345, EXCEPTION_FENCE, 32'h80000040,
                tv(32'h18029073), 1'b1);
    tick();
    checkIdle("satp_after");

    // Three stall cycles with a write held in E2
    applyStimulus(1'b1, 32'h80000050, 32'h34029073, 1'b1, 32'h0BADF00D, 32'h0, 6'h0);
    tick();
    applyBubble();
    stall_i = 1'b1;
    tick();
    checkIdle("stall1");
    tick();
    checkIdle("stall2");
    tick();
    stall_i = 1'b0;
    checkIdle("stall3");
    tick();
    checkOutput("stall_release", 1'b1, 12'h340, 32'h0BADF00D, 6'h0, 32'h80000050, tv(32'h0), 1'b0);
    tick();
    checkIdle("stall_after");

    // Back-to-back CSR writes
    applyStimulus(1'b1, 32'h80000060, 32'h34029073, 1'b1, 32'h00000001, 32'h0, 6'h0);
    tick();
    applyStimulus(1'b1, 32'h80000064, 32'h34129073, 1'b1, 32'h00000002, 32'h0, 6'h0);
    tick();
    applyBubble();
    checkOutput("b2b_first", 1'b1, 12'h340, 32'h00000001, 6'h0, 32'h80000060, tv(32'h0), 1'b0);
    tick();
    checkOutput("b2b_second", 1'b1, 12'h341, 32'h00000002, 6'h0, 32'h80000064, tv(32'h0), 1'b0);
    tick();
    checkIdle("b2b_after");

    // Squashed write never reaches WB
    applyStimulus(1'b1, 32'h80000070, 32'h34029073, 1'b1, 32'hFFFFFFFF, 32'h0, 6'h0);
    squash_e1_i = 1'b1;
    tick();
    squash_e1_i = 1'b0;
    applyBubble();
    tick();
    checkIdle("squash");

    // Reset asserted while a write sits in WB and another in E2
    applyStimulus(1'b1, 32'h80000080, 32'h34029073, 1'b1, 32'h0000AAAA, 32'h0, 6'h0);
    tick();
    applyStimulus(1'b1, 32'h80000084, 32'h34029073, 1'b1, 32'h0000BBBB, 32'h0, 6'h0);
    tick();
    applyBubble();
    checkOutput("pre_reset", 1'b1, 12'h340, 32'h0000AAAA, 6'h0, 32'h80000080, tv(32'h0), 1'b0);
    rst_i = 1'b1;
    #1;
    checkIdle("reset_async");
    tick();
    checkIdle("reset_held");
    rst_i = 1'b0;
    tick();
    checkIdle("reset_after1");
    tick();
    checkIdle("reset_after2");

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #100000;
    $display("[TB] FAIL watchdog expired");
    $fatal(1, "[TB] watchdog");
  end

endmodule
